// File: rtl/cpu_pkg.sv
// Types and constants shared by the front end (fetch_unit) and control_unit.
package cpu_pkg;

    typedef logic [3:0] op_t;

    localparam op_t OP_NOP    = 4'h0;
    localparam op_t OP_ALU    = 4'h1;
    localparam op_t OP_ALUI   = 4'h2;
    localparam op_t OP_LOAD   = 4'h3;
    localparam op_t OP_STORE  = 4'h4;
    localparam op_t OP_BRANCH = 4'h5;
    localparam op_t OP_JUMP   = 4'h6;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry shift-register FIFO; entry 0 is always the head so the head output
// comes straight from flops.
module fetch_queue #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] din,
    output logic [1:0]   count,
    output logic [W-1:0] head
);

    logic [W-1:0] e1;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 2'd0;
            head  <= '0;
            e1    <= '0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) head <= din;
                    else               e1   <= din;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head  <= e1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        head <= din;
                    end else begin
                        head <= e1;
                        e1   <= din;
                    end
                end
                default: ;
            endcase
        end
    end

    // The issue logic upstream must keep the queue from ever overfilling.
    assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && !flush && count == 2'd2));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, keeps one request in flight to instruction
// memory, buffers returned words in a 2-entry queue and handles redirects.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 32,
    parameter int                OP_LSB   = 28,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC),
    parameter int                PC_STEP  = 4
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output op_t                op
);

    localparam int ENTRY_W = INSTR_W + ADDR_W;

    fetch_state_t        state;
    logic [ADDR_W-1:0]   pc;
    logic [ADDR_W-1:0]   req_pc;
    logic                outstanding;
    logic                drop;
    logic [1:0]          q_count;
    logic [ENTRY_W-1:0]  q_head;
    logic                push;
    logic                pop;
    logic                out_after;
    logic [2:0]          occ;

    assign drop      = (state == FLUSH);
    assign pop       = instr_valid && !stall;
    assign push      = imem_rvalid && outstanding && !drop && !branch_taken;
    assign out_after = outstanding && !imem_rvalid;
    assign occ       = {1'b0, q_count} + {2'b00, push} - {2'b00, pop};

    // A stale response must come back before a new request can be matched to it.
    assign imem_req  = !rst && !branch_taken && !out_after && !(drop && !imem_rvalid)
                       && (occ < 3'd2);
    assign imem_addr = pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            outstanding <= 1'b0;
            state       <= outstanding ? FLUSH : RUN;
        end else if (branch_taken) begin
            pc          <= branch_target;
            outstanding <= out_after;
            state       <= ((drop || outstanding) && !imem_rvalid) ? FLUSH : RUN;
        end else begin
            if (imem_rvalid) begin
                outstanding <= 1'b0;
                state       <= RUN;
            end
            if (imem_req) begin
                outstanding <= 1'b1;
                pc          <= pc + ADDR_W'(PC_STEP);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (imem_req) req_pc <= pc;
    end

    fetch_queue #(.W(ENTRY_W)) u_queue (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (branch_taken),
        .din   ({imem_rdata, req_pc}),
        .count (q_count),
        .head  (q_head)
    );

    assign instr_valid = (q_count != 2'd0);
    assign instr       = q_head[ENTRY_W-1:ADDR_W];
    assign instr_pc    = q_head[ADDR_W-1:0];
    assign op          = instr[OP_LSB +: 4];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a behavioural fixed-latency instruction memory
// returning ~address as the instruction word.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [3:0]  op;

    int checks   = 0;
    int failures = 0;

    int          mem_lat  = 1;
    logic        mem_busy = 1'b0;
    int          mem_left = 0;
    logic [31:0] mem_addr = '0;

    typedef struct {
        logic        stall;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
    } vec_t;

    vec_t tbl [14];

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .op            (op)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One cycle: drive inputs and memory response at negedge, then capture any request.
    task automatic step(input logic s, input logic b, input logic [31:0] t, input logic r);
        @(negedge clk);
        rst           = r;
        stall         = s;
        branch_taken  = b;
        branch_target = t;
        imem_rvalid   = 1'b0;
        imem_rdata    = '0;
        if (mem_busy) begin
            mem_left--;
            if (mem_left == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = ~mem_addr;
                mem_busy    = 1'b0;
            end
        end
        #1;
        if (imem_req) begin
            mem_busy = 1'b1;
            mem_left = mem_lat;
            mem_addr = imem_addr;
        end
    endtask

    task automatic check_out(input string tag, input logic er, input logic [31:0] ea,
                             input logic ev, input logic [31:0] ep);
        logic [31:0] ei;
        ei = ~ep;
        chk({tag, ".req"}, 32'(imem_req), 32'(er));
        if (er) chk({tag, ".addr"}, imem_addr, ea);
        chk({tag, ".valid"}, 32'(instr_valid), 32'(ev));
        if (ev) begin
            chk({tag, ".pc"}, instr_pc, ep);
            chk({tag, ".instr"}, instr, ei);
            chk({tag, ".op"}, 32'(op), 32'(ei[31:28]));
        end
    endtask

    task automatic do_reset(input int lat);
        mem_busy = 1'b0;
        mem_lat  = lat;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
        imem_rvalid = 1'b0; imem_rdata = '0;

        tbl[0]  = '{1'b0, 1'b1, 32'd0,  1'b0, 32'd0};
        tbl[1]  = '{1'b0, 1'b1, 32'd4,  1'b0, 32'd0};
        tbl[2]  = '{1'b0, 1'b1, 32'd8,  1'b1, 32'd0};
        tbl[3]  = '{1'b0, 1'b1, 32'd12, 1'b1, 32'd4};
        tbl[4]  = '{1'b1, 1'b0, 32'd0,  1'b1, 32'd8};
        tbl[5]  = '{1'b1, 1'b0, 32'd0,  1'b1, 32'd8};
        tbl[6]  = '{1'b1, 1'b0, 32'd0,  1'b1, 32'd8};
        tbl[7]  = '{1'b1, 1'b0, 32'd0,  1'b1, 32'd8};
        tbl[8]  = '{1'b1, 1'b0, 32'd0,  1'b1, 32'd8};
        tbl[9]  = '{1'b0, 1'b1, 32'd16, 1'b1, 32'd8};
        tbl[10] = '{1'b0, 1'b1, 32'd20, 1'b1, 32'd12};
        tbl[11] = '{1'b0, 1'b1, 32'd24, 1'b1, 32'd16};
        tbl[12] = '{1'b0, 1'b1, 32'd28, 1'b1, 32'd20};
        tbl[13] = '{1'b0, 1'b1, 32'd32, 1'b1, 32'd24};

        // Reset values, sampled in the last reset cycle.
        do_reset(1);
        chk("rst.req",   32'(imem_req),    32'd0);
        chk("rst.addr",  imem_addr,        32'h0);
        chk("rst.valid", 32'(instr_valid), 32'd0);
        chk("rst.instr", instr,            32'h0);
        chk("rst.pc",    instr_pc,         32'h0);
        chk("rst.op",    32'(op),          32'd0);

        // Streaming with a 5-cycle stall window, 1-cycle memory.
        for (int i = 0; i < 14; i++) begin
            step(tbl[i].stall, 1'b0, 32'h0, 1'b0);
            check_out($sformatf("stream[%0d]", i), tbl[i].req, tbl[i].addr,
                      tbl[i].valid, tbl[i].pc);
        end

        // Redirect while a 3-cycle request is outstanding.
        do_reset(3);
        step(1'b0, 1'b0, 32'h0, 1'b0);   check_out("lat3.c0", 1'b1, 32'h0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b0);   check_out("lat3.c1", 1'b0, 32'h0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h100, 1'b0); check_out("lat3.br", 1'b0, 32'h0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b0);   check_out("lat3.c3", 1'b1, 32'h100, 1'b0, 32'h0);
        for (int i = 4; i < 7; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b0);
            chk($sformatf("lat3.c%0d.valid", i), 32'(instr_valid), 32'd0);
        end
        step(1'b0, 1'b0, 32'h0, 1'b0);   check_out("lat3.c7", 1'b0, 32'h0, 1'b1, 32'h100);

        // Redirect coincident with a response under stall, then a redirect to the top of memory.
        do_reset(1);
        step(1'b0, 1'b0, 32'h0, 1'b0);          check_out("brv.c0", 1'b1, 32'h0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b0);          check_out("brv.c1", 1'b1, 32'h4, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'h200, 1'b0);        check_out("brv.c2", 1'b0, 32'h0, 1'b1, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b0);          check_out("brv.c3", 1'b1, 32'h200, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b0);          check_out("brv.c4", 1'b1, 32'h204, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);  check_out("wrap.br", 1'b0, 32'h0, 1'b1, 32'h200);
        step(1'b0, 1'b0, 32'h0, 1'b0);          check_out("wrap.c6", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b0);          check_out("wrap.c7", 1'b1, 32'h0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b0);          check_out("wrap.c8", 1'b1, 32'h4, 1'b1, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 32'h0, 1'b0);          check_out("wrap.c9", 1'b1, 32'h8, 1'b1, 32'h0);

        // Reset pulse with a request in flight; its late response must be ignored.
        do_reset(3);
        step(1'b0, 1'b0, 32'h0, 1'b0);   check_out("rstm.c0", 1'b1, 32'h0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b0);   check_out("rstm.c1", 1'b0, 32'h0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b0);   check_out("rstm.c2", 1'b0, 32'h0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b0);   check_out("rstm.c3", 1'b1, 32'h4, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b0);   check_out("rstm.c4", 1'b0, 32'h0, 1'b1, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b0);   check_out("rstm.c5", 1'b0, 32'h0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b0);   check_out("rstm.c6", 1'b1, 32'h8, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("rstm.c7.req", 32'(imem_req), 32'd0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        chk("rstm.c8.req",   32'(imem_req),    32'd0);
        chk("rstm.c8.addr",  imem_addr,        32'h0);
        chk("rstm.c8.valid", 32'(instr_valid), 32'd0);
        chk("rstm.c8.instr", instr,            32'h0);
        chk("rstm.c8.pc",    instr_pc,         32'h0);
        chk("rstm.c8.op",    32'(op),          32'd0);
        step(1'b0, 1'b0, 32'h0, 1'b0);   check_out("rstm.c9", 1'b1, 32'h0, 1'b0, 32'h0);
        for (int i = 10; i < 13; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b0);
            chk($sformatf("rstm.c%0d.valid", i), 32'(instr_valid), 32'd0);
        end
        step(1'b0, 1'b0, 32'h0, 1'b0);   check_out("rstm.c13", 1'b0, 32'h0, 1'b1, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
